// File: rtl/seg7_time_display.sv
// Four-digit seven-segment scan driver showing a BCD time word as SS.cc.
// Define SEG7_LZB_EN to blank a leading zero in the tens-of-seconds digit.
module seg7_time_display #(
  parameter int CLK_FREQ = 100000000,
  parameter int FRAME_HZ = 250
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] time_reading,
  input  logic        blank,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int DIGIT_CYCLES = CLK_FREQ / (4 * FRAME_HZ);
  localparam int CW =
    (DIGIT_CYCLES > 2) ? $clog2(DIGIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIGIT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   frame_q, frame_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          tick;
  logic [3:0]    nib;

  function automatic logic [6:0] dec(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0111111;
    endcase
    return s;
  endfunction

  always_comb begin
    tick    = (cnt_q == CNT_MAX);
    cnt_d   = tick ? '0 : cnt_q + 1'b1;
    idx_d   = tick ? idx_q + 2'd1 : idx_q;
    frame_d = frame_q;
    // Snapshot only at the frame boundary so digits never tear
    if (tick && idx_q == 2'd3)
      frame_d = time_reading;
  end

  always_comb begin
    unique case (idx_q)
      2'd0: nib = frame_q[3:0];
      2'd1: nib = frame_q[7:4];
      2'd2: nib = frame_q[11:8];
      2'd3: nib = frame_q[15:12];
    endcase
    seg_d = dec(nib);
    dp_d  = (idx_q != 2'd2);
    an_d  = ~(4'b0001 << idx_q);
    // Dark first cycle of each slot hides segment changes
    if (blank || cnt_q == '0)
      an_d = 4'hF;
`ifdef SEG7_LZB_EN
    if (idx_q == 2'd3 && nib == 4'd0)
      an_d = 4'hF;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      idx_q   <= 2'd0;
      frame_q <= 16'h0000;
      an_q    <= 4'hF;
      seg_q   <= 7'h7F;
      dp_q    <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_seg7_time_display.sv
// Self-checking bench for seg7_time_display (DIGIT_CYCLES = 4).
// Reference model derives expected pins from elapsed cycles since reset.
module tb_seg7_time_display;

  logic        clk;
  logic        rst_n;
  logic [15:0] time_reading;
  logic        blank;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int checks = 0;
  int errors = 0;

  seg7_time_display #(
    .CLK_FREQ(16),
    .FRAME_HZ(1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .time_reading(time_reading),
    .blank       (blank),
    .an          (an),
    .seg         (seg),
    .dp          (dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] segt [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
    7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111
  };

  int          k;
  logic [15:0] m_frame;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp;
  int          e_idx;

  task automatic step();
    logic        pb;
    logic [15:0] ptr;
    int          n, slot, cnt;
    logic [3:0]  dg;
    pb  = blank;
    ptr = time_reading;
    @(posedge clk);
    #1;
    k++;
    n     = k - 1;
    slot  = n / 4;
    e_idx = slot % 4;
    cnt   = n % 4;
    dg    = 4'((m_frame >> (4 * e_idx)) & 16'hF);
    e_seg = segt[dg];
    e_dp  = (e_idx != 2);
    e_an  = 4'hF;
    if (!pb && cnt != 0) e_an[e_idx] = 1'b0;
`ifdef SEG7_LZB_EN
    if (e_idx == 3 && dg == 4'd0) e_an = 4'hF;
`endif
    if (k % 16 == 0) m_frame = ptr;
  endtask

  task automatic run_check(input string nm, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      step();
      checks++;
      if (an !== e_an || seg !== e_seg || dp !== e_dp) begin
        errors++;
        $display("FAIL %s k=%0d: an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b",
                 nm, k, an, seg, dp, e_an, e_seg, e_dp);
      end
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n   = 1'b1;
    k       = 0;
    m_frame = 16'h0000;
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    blank        = 1'b0;
    time_reading = 16'h1234;
    #2;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1) begin
        errors++;
        $display("FAIL reset_hold: an=%b seg=%b dp=%b, want 1111 1111111 1",
                 an, seg, dp);
      end
    end
    release_reset();
    step();
    checks++;
    if (an !== 4'hF) begin
      errors++;
      $display("FAIL first_edge_guard: an=%b want 1111", an);
    end
    step();
    checks++;
    if (an !== 4'b1110 || seg !== 7'b1000000) begin
      errors++;
      $display("FAIL second_edge: an=%b seg=%b want 1110 1000000", an, seg);
    end
    run_check("reset_frame0", 13);
  endtask

  task automatic test_scan();
    time_reading = 16'h5937;
    run_check("scan_latch", 1);
    run_check("scan_frame", 32);
    while (k % 16 != 0) run_check("scan_align", 1);
    for (int i = 0; i < 16; i++) begin
      step();
      if (e_an != 4'hF) begin
        checks++;
        if (seg !== segt[(16'h5937 >> (4 * e_idx)) & 16'hF]
            || an !== ~(4'b0001 << e_idx)) begin
          errors++;
          $display("FAIL scan_digit idx=%0d: an=%b seg=%b", e_idx, an, seg);
        end
      end
    end
  endtask

  task automatic test_tearing();
    time_reading = 16'h1111;
    while (k % 16 != 0) run_check("tear_wait", 1);
    run_check("tear_wait2", 16);
    run_check("tear_to_idx1", 6);
    time_reading = 16'h2222;
    run_check("tear_rest", 10);
    run_check("tear_next", 16);
    checks++;
    if (m_frame !== 16'h2222) begin
      errors++;
      $display("FAIL tear_model_frame: got %h want 2222", m_frame);
    end
  endtask

  task automatic test_invalid();
    time_reading = 16'hA0F0;
    run_check("invalid_bcd", 40);
  endtask

  task automatic test_blank();
    blank = 1'b1;
    run_check("blank_on", 20);
    blank = 1'b0;
    run_check("blank_off", 12);
  endtask

  task automatic test_reset_mid();
    while (!(((k / 4) % 4) == 2 && (k % 4) == 2))
      run_check("mid_seek", 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1) begin
      errors++;
      $display("FAIL reset_async: an=%b seg=%b dp=%b, want 1111 1111111 1",
               an, seg, dp);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_hold: an=%b seg=%b dp=%b", an, seg, dp);
    end
    release_reset();
    run_check("mid_resume", 20);
  endtask

  task automatic test_lzb();
    time_reading = 16'h0537;
    run_check("lzb", 40);
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0) time_reading = 16'($urandom);
      blank = ($urandom_range(0, 9) == 0);
      run_check("random", 1);
    end
    blank = 1'b0;
  endtask

  initial begin
    test_reset();
    test_scan();
    test_tearing();
    test_invalid();
    test_blank();
    test_reset_mid();
    test_lzb();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
